// File: rtl/data_mem.sv
// Byte-addressed data memory: combinational little-endian word reads and
// word writes on the clock edge. Byte indices wrap modulo DEPTH.

module data_mem_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int LANE       = 0
) (
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem,
  input  logic [AW-1:0]                    idx,
  output logic [DATA_WIDTH-1:0]            rd_byte
);
  logic [AW-1:0] sel;

  // AW-bit addition wraps naturally, giving the modulo-DEPTH byte index
  assign sel     = idx + AW'(LANE);
  assign rd_byte = mem[sel];
endmodule

module data_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata
);
  localparam int AW        = $clog2(DEPTH);
  localparam int NUM_LANES = 32 / DATA_WIDTH;
  localparam int LW        = $clog2(NUM_LANES);

  logic [DEPTH-1:0][DATA_WIDTH-1:0]     mem;
  logic [AW-1:0]                        idx;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rd_lanes;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wr_lanes;
  logic [DEPTH-1:0]                     wr_en;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     wr_byte;
  logic [AW-1:0]                        off;
  logic                                 unused_addr;

  assign idx         = address[AW-1:0];
  assign unused_addr = ^address[31:AW];
  assign wr_lanes    = writedata;
  assign readdata    = rd_lanes;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    data_mem_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .AW        (AW),
      .LANE      (l)
    ) u_lane (
      .mem    (mem),
      .idx    (idx),
      .rd_byte(rd_lanes[l])
    );
  end

  // Each storage byte picks its lane by its wrapped distance from idx;
  // only distances 0..NUM_LANES-1 belong to the current word.
  always_comb begin
    wr_en   = '0;
    wr_byte = '0;
    off     = '0;
    for (int b = 0; b < DEPTH; b++) begin
      off = AW'(b) - idx;
      if ({1'b0, off} < (AW+1)'(NUM_LANES)) begin
        wr_en[b]   = memwrite;
        wr_byte[b] = wr_lanes[off[LW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      for (int b = 0; b < DEPTH; b++)
        if (wr_en[b]) mem[b] <= wr_byte[b];
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// Directed plus randomized checks of data_mem against a byte-array model.

module tb_data_mem;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;

  logic [7:0] ref_mem [DEPTH];
  int n_chk  = 0;
  int n_pass = 0;

  data_mem #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .writedata(writedata),
    .memwrite (memwrite),
    .readdata (readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int base;
    base = int'(a % DEPTH);
    return {ref_mem[(base+3)%DEPTH], ref_mem[(base+2)%DEPTH],
            ref_mem[(base+1)%DEPTH], ref_mem[base]};
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    int base;
    base = int'(a % DEPTH);
    for (int k = 0; k < 4; k++) ref_mem[(base+k)%DEPTH] = d[8*k +: 8];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    address = a;
    #1;
    chk(tag, readdata, model_read(a));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; memwrite = 1'b1;
    @(posedge clk);
    model_write(a, d);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic rd_all(input string tag);
    for (int a = 0; a < DEPTH; a++) rd(tag, 32'(a));
  endtask

  initial begin
    logic [31:0] ra, rdat;
    logic        rwe;

    rst_n = 1'b0; address = '0; writedata = '0; memwrite = 1'b0;
    model_clear();
    #1;
    chk("reset_initial", readdata, 32'h0);
    #11 rst_n = 1'b1;

    // aligned write and memwrite gating
    wr(32'h0, 32'h0000_0001);
    chk("write_addr0", readdata, 32'h0000_0001);
    @(negedge clk);
    address = 32'h0; writedata = 32'hFFFF_FFFF; memwrite = 1'b0;
    @(posedge clk); #1;
    chk("hold_no_write", readdata, 32'h0000_0001);

    // byte order
    wr(32'h4, 32'hDEAD_BEEF);
    address = 32'h4; #1;
    chk("le_addr4", readdata, 32'hDEAD_BEEF);
    address = 32'h5; #1;
    chk("le_addr5", readdata, 32'h00DE_ADBE);

    // wrap and aliasing
    wr(32'd14, 32'h1122_3344);
    address = 32'd14; #1;
    chk("wrap_addr14", readdata, 32'h1122_3344);
    address = 32'h0; #1;
    chk("wrap_low_bytes", readdata[15:0], 16'h1122);
    address = 32'h10; #1;
    chk("alias_0x10", readdata, model_read(32'h0));
    chk("alias_0x10_model", readdata, {ref_mem[3], ref_mem[2], 8'h11, 8'h22});

    // read during write
    wr(32'h8, 32'hAAAA_AAAA);
    @(negedge clk);
    address = 32'h8; writedata = 32'h5555_5555; memwrite = 1'b1;
    #1;
    chk("rdw_before", readdata, 32'hAAAA_AAAA);
    @(posedge clk); #1;
    chk("rdw_after", readdata, 32'h5555_5555);
    model_write(32'h8, 32'h5555_5555);
    memwrite = 1'b0;
    rd_all("directed_all");

    // randomized traffic with misaligned and aliased addresses
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ra = $urandom; rdat = $urandom; rwe = 1'($urandom_range(0, 1));
      address = ra; writedata = rdat; memwrite = rwe;
      #1;
      chk("rand_pre", readdata, model_read(ra));
      @(posedge clk);
      if (rwe) model_write(ra, rdat);
      #1;
      chk("rand_post", readdata, model_read(ra));
      memwrite = 1'b0;
      rd("rand_other", $urandom);
    end

    // unknown address with memwrite low must not disturb storage
    @(negedge clk);
    address = 'x; writedata = $urandom; memwrite = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rd_all("x_addr_all");

    // async reset mid-write: clears at once, suppresses writes
    @(negedge clk);
    address = 32'h4; writedata = 32'h1234_5678; memwrite = 1'b1;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    for (int a = 0; a < DEPTH; a += 4) begin
      address = 32'(a); #1;
      chk("reset_async_zero", readdata, 32'h0);
    end
    address = 32'h4;
    @(posedge clk); @(posedge clk); #1;
    rd_all("reset_no_write");

    // release mid-cycle; next edge performs a normal write
    @(negedge clk);
    #2 rst_n = 1'b1;
    address = 32'd13; writedata = 32'hCAFE_F00D; memwrite = 1'b1;
    @(posedge clk);
    model_write(32'd13, 32'hCAFE_F00D);
    #1;
    memwrite = 1'b0;
    chk("post_reset_write", readdata, 32'hCAFE_F00D);
    rd_all("post_reset_all");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
